// File: rtl/maze_move_sequencer.sv
// Move-command sequencer for the MazeSolver bot: queues explorer moves, hands them
// one at a time to the motion executor, and tracks pose, dead ends, exit and errors.
module maze_move_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GRID       = 9,
  parameter int START_X    = 4,
  parameter int START_Y    = 8,
  parameter int EXIT_X     = 4,
  parameter int EXIT_Y     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       cmd_ready,
  output logic       exec_valid,
  output logic [2:0] exec_cmd,
  input  logic       exec_done,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [1:0] heading,
  output logic [3:0] deadend_cnt,
  output logic       exit_reached,
  output logic       err,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_U_TURN = 3'd4;
  localparam logic signed [5:0] GRID_S = 6'(GRID);
  localparam logic [3:0] EXIT_XV = 4'(EXIT_X);
  localparam logic [3:0] EXIT_YV = 4'(EXIT_Y);

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;
  state_t state, state_next;

  logic [2:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop, done_move, flush;
  logic [1:0]    new_heading;
  logic signed [5:0] nx, ny;
  logic          off_grid, at_exit;

  function automatic logic [1:0] turn(input logic [2:0] c, input logic [1:0] h);
    case (c)
      CMD_LEFT:   turn = h - 2'd1;
      CMD_RIGHT:  turn = h + 2'd1;
      CMD_U_TURN: turn = h + 2'd2;
      default:    turn = h;
    endcase
  endfunction

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full && !exit_reached && !err;
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && (cmd != CMD_STOP) && (cmd <= CMD_U_TURN);
  assign busy       = !fifo_empty || exec_valid;

  // Candidate pose for the command currently at the executor
  always_comb begin
    new_heading = turn(exec_cmd, heading);
    nx = $signed({2'b00, pos_x});
    ny = $signed({2'b00, pos_y});
    case (new_heading)
      2'd0:    ny = ny - 6'sd1;
      2'd1:    nx = nx + 6'sd1;
      2'd2:    ny = ny + 6'sd1;
      default: nx = nx - 6'sd1;
    endcase
  end

  assign off_grid = (nx < 6'sd0) || (ny < 6'sd0) || (nx >= GRID_S) || (ny >= GRID_S);
  assign at_exit  = (nx[3:0] == EXIT_XV) && (ny[3:0] == EXIT_YV);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done_move  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          done_move = 1'b1;
          if (off_grid || at_exit) state_next = HALT;
          else                     state_next = IDLE;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign flush = done_move && !off_grid && at_exit;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      exec_valid   <= 1'b0;
      exec_cmd     <= CMD_STOP;
      pos_x        <= 4'(START_X);
      pos_y        <= 4'(START_Y);
      heading      <= 2'd0;
      deadend_cnt  <= 4'd0;
      exit_reached <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (pop) begin
        exec_valid <= 1'b1;
        exec_cmd   <= fifo_mem[rd_ptr];
      end
      if (done_move) begin
        exec_valid <= 1'b0;
        if (exec_cmd == CMD_U_TURN && deadend_cnt != 4'd15)
          deadend_cnt <= deadend_cnt + 4'd1;
        if (off_grid) begin
          err <= 1'b1;
        end else begin
          pos_x   <= nx[3:0];
          pos_y   <= ny[3:0];
          heading <= new_heading;
          if (at_exit) exit_reached <= 1'b1;
        end
      end
      if (accept && cmd > CMD_U_TURN) err <= 1'b1;
      // A push landing in the flush cycle is discarded with the rest of the queue
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
